// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared word/PC types, constants and queue entry layout for the fetch front end
package proc_pkg;

   localparam int WORD_W      = 32;
   localparam int INSTR_BYTES = 4;

   typedef logic [WORD_W-1:0] pc_t;
   typedef logic [WORD_W-1:0] word_t;

   localparam pc_t DEFAULT_RESET_PC = 32'h0000_0000;

   // One buffered instruction together with the address it was fetched from
   typedef struct packed {
      pc_t   pc;
      word_t data;
   } fetch_entry_t;

   // Instruction addresses are always word aligned; low bits are discarded
   function automatic pc_t align_pc(input pc_t pc);
      return {pc[WORD_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/instr_prefetch_if.sv
// rtl/instr_prefetch_if.sv - fetch-stage bus: imem request/response, redirect and instruction handshake
interface instr_prefetch_if;
   import proc_pkg::*;

   logic  imem_req;
   pc_t   imem_addr;
   logic  imem_gnt;
   logic  imem_rvalid;
   word_t imem_rdata;
   logic  redir_valid;
   pc_t   redir_pc;
   logic  inst_valid;
   logic  inst_ready;
   word_t inst_data;
   pc_t   inst_pc;

   // Prefetch stage side
   modport master (
      output imem_req, imem_addr,
      input  imem_gnt, imem_rvalid, imem_rdata,
      input  redir_valid, redir_pc,
      output inst_valid, inst_data, inst_pc,
      input  inst_ready
   );

   // Memory / branch unit / consumer side
   modport slave (
      input  imem_req, imem_addr,
      output imem_gnt, imem_rvalid, imem_rdata,
      output redir_valid, redir_pc,
      input  inst_valid, inst_data, inst_pc,
      output inst_ready
   );

endinterface

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - in-order circular buffer of {pc, data} entries with push/pop/flush
module instr_fifo
   import proc_pkg::*;
#(
   parameter int QDEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic                      push,
   input  fetch_entry_t              push_entry,
   input  logic                      pop,
   output logic [$clog2(QDEPTH):0]   occupancy,
   output fetch_entry_t              head
);

   localparam int CW = $clog2(QDEPTH) + 1;
   localparam int PW = $clog2(QDEPTH);

   fetch_entry_t  mem [QDEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          empty;
   logic          full;
   logic          do_push;
   logic          do_pop;

   assign empty   = (occupancy == '0);
   assign full    = (occupancy == CW'(QDEPTH));
   assign do_pop  = pop && !empty;
   // A full queue still accepts a push when the head leaves in the same cycle
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   // Pointers and occupancy; flush wins over any same-cycle push or pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         occupancy <= '0;
      end else if (flush) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         occupancy <= occupancy + CW'(do_push) - CW'(do_pop);
      end
   end

   // Entry storage; cleared on reset so the head reads as zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < QDEPTH; i++) mem[i] <= '0;
      end else if (do_push && !flush) begin
         mem[wr_ptr] <= push_entry;
      end
   end

endmodule

// File: rtl/instr_prefetch.sv
// rtl/instr_prefetch.sv - PC owner, fetch credit, stale-response drop and redirect; optional INSTR_PREFETCH_BYPASS_EN
module instr_prefetch
   import proc_pkg::*;
#(
   parameter pc_t RESET_PC = DEFAULT_RESET_PC,
   parameter int  QDEPTH   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   instr_prefetch_if.master  bus
);

   localparam int CW = $clog2(QDEPTH) + 1;

   pc_t          fetch_pc;
   pc_t          resp_pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] drop_cnt;
   logic [CW-1:0] occupancy;
   logic [CW-1:0] out_next;
   logic [CW-1:0] occ_next;
   logic          req_q;
   logic          credit_ok;
   logic          gnt_fire;
   logic          rsp_ok;
   logic          rsp_accept;
   logic          flush;
   logic          push;
   logic          pop_q;
   fetch_entry_t  head;

   assign flush      = bus.redir_valid;
   assign gnt_fire   = req_q && bus.imem_gnt;
   // A response with nothing outstanding is a protocol error and is ignored
   assign rsp_ok     = bus.imem_rvalid && (outstanding != '0);
   // Responses arriving in a redirect cycle are wrong-path by definition
   assign rsp_accept = rsp_ok && (drop_cnt == '0) && !flush;
   assign pop_q      = (occupancy != '0) && bus.inst_ready;

`ifdef INSTR_PREFETCH_BYPASS_EN
   logic byp;

   assign byp            = rsp_accept && (occupancy == '0);
   assign bus.inst_valid = (occupancy != '0) || byp;
   assign bus.inst_data  = byp ? bus.imem_rdata : head.data;
   assign bus.inst_pc    = byp ? resp_pc : head.pc;
   assign push           = rsp_accept && !(byp && bus.inst_ready);
`else
   assign bus.inst_valid = (occupancy != '0);
   assign bus.inst_data  = head.data;
   assign bus.inst_pc    = head.pc;
   assign push           = rsp_accept;
`endif

   assign bus.imem_req  = req_q;
   assign bus.imem_addr = fetch_pc;

   // Credit is judged on post-edge state, so a pop only frees a slot one cycle later
   assign out_next  = outstanding + CW'(gnt_fire) - CW'(rsp_ok);
   assign occ_next  = flush ? '0 : (occupancy + CW'(push) - CW'(pop_q));
   assign credit_ok = ({1'b0, occ_next} + {1'b0, out_next}) < (CW+1)'(QDEPTH);

   instr_fifo #(.QDEPTH(QDEPTH)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .push       (push),
      .push_entry ('{pc: resp_pc, data: bus.imem_rdata}),
      .pop        (pop_q),
      .occupancy  (occupancy),
      .head       (head)
   );

   // Fetch PC, response PC, in-flight and drop bookkeeping plus the registered request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         req_q       <= 1'b0;
      end else begin
         outstanding <= out_next;
         req_q       <= credit_ok;
         if (flush) begin
            fetch_pc <= align_pc(bus.redir_pc);
            resp_pc  <= align_pc(bus.redir_pc);
            drop_cnt <= out_next;
         end else begin
            if (gnt_fire)                      fetch_pc <= fetch_pc + pc_t'(INSTR_BYTES);
            if (rsp_accept)                    resp_pc  <= resp_pc + pc_t'(INSTR_BYTES);
            if (rsp_ok && (drop_cnt != '0))    drop_cnt <= drop_cnt - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_instr_prefetch.sv
// tb/tb_instr_prefetch.sv - scoreboard bench with a latency-modelled instruction memory
module tb_instr_prefetch;
   import proc_pkg::*;

   localparam int  QDEPTH = 4;
   localparam pc_t RST_PC = 32'h0000_0000;

   typedef struct {
      pc_t addr;
      int  epoch;
      int  due;
   } req_t;

   typedef struct {
      pc_t   pc;
      word_t data;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   instr_prefetch_if bus();

   instr_prefetch #(.RESET_PC(RST_PC), .QDEPTH(QDEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fail   = 0;
   req_t pend[$];
   exp_t exp_q[$];
   int   cyc = 0;
   int   epoch = 0;
   int   last_due = 0;
   int   grants = 0;
   int   n_deliv = 0;
   pc_t  last_pc = '0;
   pc_t  model_pc = RST_PC;
   pc_t  last_grant_addr = '0;
   pc_t  hold_addr = '0;
   bit   hold_prev = 0;
   bit   prev_redir = 0;
   int   p_gnt = 100, p_ready = 100, p_redir = 0;
   int   lat_min = 1, lat_max = 1;
   bit   force_redir = 0;
   pc_t  force_pc = '0;
   int   first_rsp = -1, first_valid = -1;

   function automatic word_t mem_word(input pc_t a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus: memory response, random handshakes, grant bookkeeping
   task automatic step();
      req_t r;
      bit   rsp_this;
      bit   do_redir;
      int   lat;
      int   due;
      pc_t  tgt;
      @(negedge clk);
      cyc++;
      rsp_this = 0;
      r = '{addr: '0, epoch: -1, due: 0};
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         r = pend.pop_front();
         rsp_this = 1;
         bus.imem_rvalid = 1'b1;
         bus.imem_rdata  = mem_word(r.addr);
      end
      bus.imem_gnt   = ($urandom_range(0, 99) < p_gnt);
      bus.inst_ready = ($urandom_range(0, 99) < p_ready);
      do_redir = force_redir || ($urandom_range(0, 999) < p_redir);
      if (force_redir) tgt = force_pc;
      else if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFE0 | pc_t'($urandom_range(0, 31));
      else tgt = $urandom;
      force_redir = 0;
      bus.redir_valid = do_redir;
      bus.redir_pc    = tgt;
      #1;
      if (prev_redir) check("valid_after_redirect", 32'(bus.inst_valid), 32'd0);
      if (hold_prev && bus.imem_req) check("addr_stable", bus.imem_addr, hold_addr);
      if (bus.imem_req && bus.imem_gnt) begin
         check("fetch_addr", bus.imem_addr, model_pc);
         lat = $urandom_range(lat_min, lat_max);
         due = cyc + lat;
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         pend.push_back('{addr: bus.imem_addr, epoch: epoch, due: due});
         last_grant_addr = bus.imem_addr;
         model_pc = model_pc + 32'd4;
         grants++;
      end
      hold_prev = bus.imem_req && !bus.imem_gnt && !do_redir;
      hold_addr = bus.imem_addr;
      if (rsp_this && r.epoch == epoch && !do_redir)
         exp_q.push_back('{pc: r.addr, data: mem_word(r.addr)});
      if (rsp_this && first_rsp < 0) first_rsp = cyc;
      if (bus.inst_valid && first_valid < 0) first_valid = cyc;
      #3;
      if (do_redir) begin
         exp_q.delete();
         epoch++;
         model_pc = {tgt[31:2], 2'b00};
      end
      prev_redir = do_redir;
   endtask

   task automatic idle_inputs();
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
      bus.redir_valid = 1'b0;
      bus.redir_pc    = '0;
      bus.inst_ready  = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req"},   32'(bus.imem_req), 32'd0);
      check({tag, "_addr"},  bus.imem_addr, RST_PC);
      check({tag, "_valid"}, 32'(bus.inst_valid), 32'd0);
      check({tag, "_data"},  bus.inst_data, 32'd0);
      check({tag, "_pc"},    bus.inst_pc, 32'd0);
   endtask

   // Asynchronous reset in the middle of a clock, with memory and model reset too
   task automatic mid_reset();
      @(negedge clk);
      idle_inputs();
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      pend.delete();
      exp_q.delete();
      epoch++;
      model_pc   = RST_PC;
      last_due   = cyc;
      hold_prev  = 0;
      prev_redir = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic redirect_to(input pc_t pc);
      force_redir = 1;
      force_pc    = pc;
      step();
   endtask

   // Scoreboard monitor: compares every accepted instruction against the model
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (rst_n && bus.inst_valid && bus.inst_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_inst: got pc %h data %h, scoreboard empty", bus.inst_pc, bus.inst_data);
            end else begin
               e = exp_q.pop_front();
               check("inst_pc", bus.inst_pc, e.pc);
               check("inst_data", bus.inst_data, e.data);
            end
            n_deliv++;
            last_pc = bus.inst_pc;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      int bound;
      idle_inputs();
      #2;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Streaming from reset: latency 1, always granted and consumed
      for (int i = 0; i < 12; i++) step();
`ifdef INSTR_PREFETCH_BYPASS_EN
      check("first_latency", 32'(first_valid - first_rsp), 32'd0);
`else
      check("first_latency", 32'(first_valid - first_rsp), 32'd1);
`endif

      // Grant withheld: address holds at 0x8 then advances to 0xC
      mid_reset();
      bound = 0;
      while (model_pc != 32'h8 && bound < 20) begin step(); bound++; end
      check("reach_pc8", model_pc, 32'h8);
      p_gnt = 0;
      for (int i = 0; i < 3; i++) step();
      check("gnt_hold_addr", bus.imem_addr, 32'h8);
      check("gnt_hold_req", 32'(bus.imem_req), 32'd1);
      p_gnt = 100;
      step();
      p_gnt = 0;
      step();
      check("after_gnt_addr", bus.imem_addr, 32'hC);

      // Consumer stalled: exactly QDEPTH grants, then request drops
      redirect_to(32'h100);
      bound = 0;
      while (pend.size() != 0 && bound < 50) begin step(); bound++; end
      check("drain_pending", 32'(pend.size()), 32'd0);
      step();
      p_gnt = 100; p_ready = 0; grants = 0;
      for (int i = 0; i < 10; i++) step();
      check("stall_grants", 32'(grants), 32'(QDEPTH));
      check("stall_req_low", 32'(bus.imem_req), 32'd0);
      p_ready = 100;
      for (int i = 0; i < 12; i++) step();

      // Latency 3: redirect with requests in flight drops stale responses
      lat_min = 3; lat_max = 3;
      for (int i = 0; i < 8; i++) step();
      check("inflight_ge2", 32'(pend.size() >= 2), 32'd1);
      redirect_to(32'h100);
      n0 = n_deliv;
      bound = 0;
      while (n_deliv == n0 && bound < 30) begin step(); bound++; end
      check("post_redirect_pc", last_pc, 32'h100);

      // Latency 1: redirect coinciding with a response and a pop
      lat_min = 1; lat_max = 1;
      for (int i = 0; i < 6; i++) step();
      redirect_to(32'h100);
      step();
      check("redirect_next_fetch", last_grant_addr, 32'h100);

      // PC wraps past the top of the address space
      redirect_to(32'hFFFF_FFF8);
      for (int i = 0; i < 3; i++) step();
      check("wrap_addr", last_grant_addr, 32'h0);

      // Randomized traffic with redirects and a reset in the middle
      p_gnt = 70; p_ready = 70; p_redir = 30; lat_min = 1; lat_max = 4;
      for (int i = 0; i < 1000; i++) step();
      mid_reset();
      for (int i = 0; i < 1000; i++) step();

      // Final drain: everything expected must have been delivered
      p_redir = 0; p_gnt = 0; p_ready = 100;
      bound = 0;
      while ((pend.size() != 0 || exp_q.size() != 0) && bound < 200) begin step(); bound++; end
      check("final_drain", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_prefetch.md
# instr_prefetch

Instruction prefetch stage sitting directly upstream of the processor's control unit and datapath. It owns the PC and issues word fetches to instruction memory over a request/grant/response interface. Returned words are buffered in a small in-order queue, and each instruction is presented downstream with a valid/ready handshake. A redirect from branch resolution flushes all wrong-path state.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset; bits [1:0] must be 0
- QDEPTH, 4, instruction queue depth; power of two, 2..16
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request valid
- imem_addr  out  32  word-aligned fetch address
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response valid; responses return in request order, latency ≥1 cycle
- imem_rdata  in  32  fetched instruction word
- redir_valid  in  1  redirect PC (taken branch / jump)
- redir_pc  in  32  redirect target; bits [1:0] ignored, forced to 0
- inst_valid  out  1  instruction available
- inst_ready  in  1  consumer accepts instruction
- inst_data  out  32  instruction word
- inst_pc  out  32  address of inst_data

## Operation
- Registers:
  - fetch PC
  - queue of QDEPTH {pc, data} entries with rd/wr pointers and occupancy
  - outstanding counter (granted, response pending)
  - drop counter (stale responses to discard)
  - counter width: $clog2(QDEPTH)+1
- Issue rule: imem_req=1 when occupancy + outstanding < QDEPTH. Credit is conservative: a pop in the same cycle does not free a slot until the next cycle.
- imem_addr = fetch PC.
- On imem_gnt && imem_req:
  - fetch PC += 4, wrapping modulo 2^32
  - outstanding += 1
- While imem_req && !imem_gnt, imem_addr is held stable, except on redirect.
- On imem_rvalid:
  - outstanding -= 1
  - if drop counter > 0: decrement it and discard the word
  - otherwise write {pc, data} at the tail; the entry's pc is tracked by a separate response-PC register that advances by 4 per accepted response
- Downstream: inst_valid = occupancy ≠ 0. inst_data/inst_pc come from the head entry. A pop occurs on inst_valid && inst_ready.
- Redirect (redir_valid=1), applied at the clock edge:
  - queue flushed: occupancy 0, pointers reset
  - fetch PC and response-PC set to {redir_pc[31:2], 2'b00}
  - drop counter set to outstanding after this cycle's grant and response, i.e. outstanding + gnt − rvalid; the response arriving in the redirect cycle is itself discarded
  - a pop in the same cycle counts as accepted by the consumer; inst_valid is 0 the following cycle
- Simultaneous push and pop on a full queue is legal. This case cannot arise from the credit rule but must not corrupt state.
- An imem_rvalid with outstanding = 0 is a protocol error: ignore it and leave counters unchanged.

## Timing
- Reset values:
  - imem_req 0, imem_addr RESET_PC
  - inst_valid 0, inst_data 0, inst_pc 0
  - queue empty; all counters 0
- First imem_req=1 occurs in the first cycle after rst_n deasserts.
- Latency:
  - without bypass: response at edge N, inst_valid at cycle N+1
  - with bypass: see Configuration
- Sustained throughput is 1 instruction/cycle when imem_gnt=1, memory latency < QDEPTH, and inst_ready=1.
- Reset asserted mid-operation clears all state immediately. In-flight responses after reset release are the memory's responsibility; memory must also be reset.

## Configuration
- INSTR_PREFETCH_BYPASS_EN defined:
  - when the queue is empty, drop counter = 0, and imem_rvalid=1, the response is driven combinationally on inst_valid/inst_data/inst_pc in the same cycle
  - if inst_ready=1, the word is consumed without being written to the queue; otherwise it is enqueued
  - redir_valid in that cycle suppresses bypass
- Undefined: every accepted response is written to the queue first, giving +1 cycle latency. Outputs are purely registered from queue state.

## Structure
- Shared package `proc_pkg`:
  - WORD_W = 32
  - INSTR_BYTES = 4
  - default RESET_PC constant
  - pc_t / word_t typedefs
- One sub-module, `instr_fifo`: parameterised QDEPTH circular buffer with push/pop/flush, occupancy, and head outputs. instr_prefetch holds the PC, credit, drop and redirect logic.

## Test plan
- Reset release, imem latency 1, gnt=1, inst_ready=1 → fetches 0x0, 0x4, 0x8 on consecutive cycles; inst_pc sequence 0x0, 0x4, 0x8 with 1-cycle latency without bypass, 0 extra cycles with bypass.
- inst_ready=0 for 10 cycles → exactly 4 grants total; imem_req drops to 0; after inst_ready=1 the queue drains in order with no loss.
- Latency 3, redirect to 0x100 with 2 requests outstanding → both stale responses dropped; next inst_valid has inst_pc=0x100.
- Redirect in the same cycle as imem_rvalid and an inst_ready pop → popped word counted as delivered; the arriving word is dropped; next fetch address is 0x100.
- imem_gnt held 0 for 3 cycles → imem_addr stable at 0x8; after gnt, PC advances to 0xC.
- PC at 0xFFFF_FFFC granted → next imem_addr is 0x0000_0000; rst_n pulsed low mid-stream → outputs return to reset values asynchronously.
